// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit-to-16-bit SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_BASE_ADDR = 1024;
  localparam int unsigned SRAM_ADDR_W    = 18;
  localparam int unsigned SRAM_DATA_W    = 16;
  localparam int unsigned WORD_W         = SRAM_ADDR_W - 1;
  localparam int unsigned CNT_W          = 3;
  localparam int unsigned BUS_W          = 2 * SRAM_DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] tag;
    logic [BUS_W-1:0]  data;
  } cache_entry_t;

  // Word index: byte offset from the SRAM window, low two bits dropped, wraps modulo 2^19.
  function automatic logic [WORD_W-1:0] word_index(input logic [31:0] byte_addr);
    return WORD_W'((byte_addr - 32'(SRAM_BASE_ADDR)) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM phases (LOW, HIGH).
// Optional one-entry read cache is enabled by defining SRAM_WORD_CACHE_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [BUS_W-1:0]   rd_q;
  logic [WORD_W-1:0]  word_c;
  logic               req_c;
  logic               is_write_c;
  logic               phase_last_c;
  logic               hit_c;

  assign word_c       = word_index(address);
  assign req_c        = rd_en | wr_en;
  assign is_write_c   = wr_en;
  assign phase_last_c = (cnt == CNT_W'(WAIT_CYCLES));

`ifdef SRAM_WORD_CACHE_EN
  cache_entry_t cache;

  // A hit is answered in IDLE straight from the entry; no SRAM cycle is started.
  assign hit_c     = rd_en & ~wr_en & cache.valid & (cache.tag == word_c) & (state == IDLE);
  assign read_data = hit_c ? cache.data : rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cache <= '0;
    end else if (state == DONE) begin
      if (is_write_c) begin
        if (cache.tag == word_c) cache.valid <= 1'b0;
      end else begin
        cache <= '{valid: 1'b1, tag: word_c, data: rd_q};
      end
    end
  end
`else
  assign hit_c     = 1'b0;
  assign read_data = rd_q;
`endif

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state, phase count and ready; the counter clears whenever a phase ends.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req_c | hit_c;
        if (req_c && !hit_c) state_next = LOW;
      end
      LOW: begin
        if (phase_last_c) state_next = HIGH;
        else              cnt_next   = cnt + 1'b1;
      end
      HIGH: begin
        if (phase_last_c) state_next = DONE;
        else              cnt_next   = cnt + 1'b1;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // SRAM pins are registered from the upcoming state so they line up with LOW/HIGH.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      rd_q        <= '0;
    end else begin
      case (state_next)
        LOW: begin
          sram_addr   <= {word_c, 1'b0};
          sram_dq_out <= write_data[SRAM_DATA_W-1:0];
          sram_dq_oe  <= is_write_c;
          sram_we_n   <= ~is_write_c;
        end
        HIGH: begin
          sram_addr   <= {word_c, 1'b1};
          sram_dq_out <= write_data[BUS_W-1:SRAM_DATA_W];
          sram_dq_oe  <= is_write_c;
          sram_we_n   <= ~is_write_c;
        end
        default: begin
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end
      endcase
      if (!is_write_c && phase_last_c) begin
        if (state == LOW)  rd_q[SRAM_DATA_W-1:0]     <= sram_dq_in;
        if (state == HIGH) rd_q[BUS_W-1:SRAM_DATA_W] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench: one controller at WAIT_CYCLES=1, one at WAIT_CYCLES=3,
// each on its own behavioural SRAM that needs a full-phase write strobe to commit.
module tb_sram_controller;

`ifdef SRAM_WORD_CACHE_EN
  localparam int HIT_LAT = 0;
`else
  localparam int HIT_LAT = 5;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en      [2];
  logic        rd_en      [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];
  logic [17:0] sram_addr  [2];
  logic [15:0] dq_out     [2];
  logic [15:0] dq_in      [2];
  logic        dq_oe      [2];
  logic        we_n       [2];

  bit   [15:0] mem0 [262144];
  bit   [15:0] mem1 [262144];
  int          wcnt0, wcnt1;
  logic [17:0] wa0, wa1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          we_low [2];
  logic [17:0] aq [$];

  sram_controller u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .address(address[0]),
    .write_data(write_data[0]), .read_data(read_data[0]), .ready(ready[0]),
    .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]), .sram_dq_in(dq_in[0]),
    .sram_dq_oe(dq_oe[0]), .sram_we_n(we_n[0])
  );

  sram_controller #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .address(address[1]),
    .write_data(write_data[1]), .read_data(read_data[1]), .ready(ready[1]),
    .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]), .sram_dq_in(dq_in[1]),
    .sram_dq_oe(dq_oe[1]), .sram_we_n(we_n[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dq_in[0] = mem0[sram_addr[0]];
  assign dq_in[1] = mem1[sram_addr[1]];

  // SRAM write commits only after the strobe has been held for a whole phase at one address.
  always @(posedge clk) begin
    if (!we_n[0] && dq_oe[0]) begin
      wcnt0 = (sram_addr[0] == wa0) ? wcnt0 + 1 : 1;
      wa0   = sram_addr[0];
      if (wcnt0 == 2) mem0[sram_addr[0]] = dq_out[0];
    end else begin
      wcnt0 = 0;
      wa0   = '1;
    end
    if (!we_n[1] && dq_oe[1]) begin
      wcnt1 = (sram_addr[1] == wa1) ? wcnt1 + 1 : 1;
      wa1   = sram_addr[1];
      if (wcnt1 == 4) mem1[sram_addr[1]] = dq_out[1];
    end else begin
      wcnt1 = 0;
      wa1   = '1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if ((wr_en[i] | rd_en[i]) && !ready[i] && !we_n[i]) we_low[i]++;
    if ((wr_en[1] | rd_en[1]) && !ready[1]) aq.push_back(sram_addr[1]);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request just after a rising edge (cycle 0), wait for ready, then release it.
  task automatic access(input int s, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rdata);
    @(posedge clk);
    #1;
    we_low[s] = 0;
    aq.delete();
    wr_en[s] = w; rd_en[s] = r; address[s] = a; write_data[s] = d;
    lat   = -1;
    rdata = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready[s]) begin
        lat   = c;
        rdata = read_data[s];
        break;
      end
    end
    wr_en[s] = 1'b0;
    rd_en[s] = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic [17:0] addr_before;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_en[i] = 1'b0; rd_en[i] = 1'b0; address[i] = '0; write_data[i] = '0; we_low[i] = 0;
    end
    wcnt0 = 0; wcnt1 = 0; wa0 = '1; wa1 = '1;
    mem1[2] = 16'hBEAD; mem1[3] = 16'hFACE;
    mem0[4] = 16'h3333; mem0[5] = 16'h7777;

    repeat (2) @(negedge clk);
    check_eq("rst_ready",     32'(ready[0]),     32'h1);
    check_eq("rst_read_data", read_data[0],      32'h0);
    check_eq("rst_sram_addr", 32'(sram_addr[0]), 32'h0);
    check_eq("rst_we_n",      32'(we_n[0]),      32'h1);
    check_eq("rst_oe",        32'(dq_oe[0]),     32'h0);
    check_eq("rst_dq_out",    32'(dq_out[0]),    32'h0);
    rst = 1'b0;

    access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, rd);
    check_eq("wr1024_lat",    32'(lat),       32'd5);
    check_eq("wr1024_hw0",    32'(mem0[0]),   32'hBEEF);
    check_eq("wr1024_hw1",    32'(mem0[1]),   32'hDEAD);
    check_eq("wr1024_strobe", 32'(we_low[0]), 32'd4);

    access(0, 1'b0, 1'b1, 32'd1024, 32'h0, lat, rd);
    check_eq("rd1024_lat",    32'(lat),       32'd5);
    check_eq("rd1024_data",   rd,             32'hDEADBEEF);
    check_eq("rd1024_strobe", 32'(we_low[0]), 32'd0);

    access(0, 1'b1, 1'b1, 32'd1028, 32'h12345678, lat, rd);
    check_eq("rdwr_lat",  32'(lat),     32'd5);
    check_eq("rdwr_data", rd,           32'hDEADBEEF);
    check_eq("rdwr_hw2",  32'(mem0[2]), 32'h5678);
    check_eq("rdwr_hw3",  32'(mem0[3]), 32'h1234);

    access(0, 1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, lat, rd);
    check_eq("wrap_hw_lo", 32'(mem0[18'h3FFFE]), 32'hF00D);
    check_eq("wrap_hw_hi", 32'(mem0[18'h3FFFF]), 32'hCAFE);

    access(0, 1'b0, 1'b1, 32'd1027, 32'h0, lat, rd);
    check_eq("rd1027_lat",  32'(lat), 32'(HIT_LAT));
    check_eq("rd1027_data", rd,       32'hDEADBEEF);

    access(1, 1'b0, 1'b1, 32'd1028, 32'h0, lat, rd);
    check_eq("w3_lat",   32'(lat),       32'd9);
    check_eq("w3_data",  rd,             32'hFACEBEAD);
    check_eq("w3_nsamp", 32'(aq.size()), 32'd9);
    if (aq.size() == 9) begin
      check_eq("w3_addr_c0", 32'(aq[0]), 32'd0);
      check_eq("w3_addr_c1", 32'(aq[1]), 32'd2);
      check_eq("w3_addr_c4", 32'(aq[4]), 32'd2);
      check_eq("w3_addr_c5", 32'(aq[5]), 32'd3);
      check_eq("w3_addr_c8", 32'(aq[8]), 32'd3);
    end

    access(0, 1'b0, 1'b1, 32'd1032, 32'h0, lat, rd);
    check_eq("c_rd1_lat",  32'(lat), 32'd5);
    check_eq("c_rd1_data", rd,       32'h77773333);
    addr_before = sram_addr[0];
    access(0, 1'b0, 1'b1, 32'd1032, 32'h0, lat, rd);
    check_eq("c_rd2_lat",  32'(lat),          32'(HIT_LAT));
    check_eq("c_rd2_data", rd,                32'h77773333);
    check_eq("c_rd2_addr", 32'(sram_addr[0]), 32'(addr_before));
    access(0, 1'b1, 1'b0, 32'd1032, 32'h0BADCAFE, lat, rd);
    check_eq("c_wr_lat", 32'(lat), 32'd5);
    access(0, 1'b0, 1'b1, 32'd1032, 32'h0, lat, rd);
    check_eq("c_rd3_lat",  32'(lat), 32'd5);
    check_eq("c_rd3_data", rd,       32'h0BADCAFE);

    // Reset lands on the first HIGH cycle of a write to 1040 (halfwords 8 and 9).
    @(posedge clk);
    #1;
    wr_en[0] = 1'b1; address[0] = 32'd1040; write_data[0] = 32'hA5A55A5A;
    repeat (4) @(negedge clk);
    check_eq("abort_pre_we_n", 32'(we_n[0]),      32'h0);
    check_eq("abort_pre_addr", 32'(sram_addr[0]), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_we_n",  32'(we_n[0]),  32'h1);
    check_eq("abort_oe",    32'(dq_oe[0]), 32'h0);
    check_eq("abort_ready", 32'(ready[0]), 32'h0);
    check_eq("abort_rdata", read_data[0],  32'h0);
    rst = 1'b0;
    wr_en[0] = 1'b0;
    @(negedge clk);
    check_eq("abort_idle_ready", 32'(ready[0]), 32'h1);
    check_eq("abort_hw8",        32'(mem0[8]),  32'h5A5A);
    check_eq("abort_hw9",        32'(mem0[9]),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra hold cycles per 16-bit SRAM phase, valid range 0..7.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wr_en  input  1  MEM-stage store request; SHALL be held stable while ready=0.
REQ-005 rd_en  input  1  MEM-stage load request; SHALL be held stable while ready=0.
REQ-006 address  input  32  ARM byte address (base 1024).
REQ-007 write_data  input  32  store word.
REQ-008 read_data  output  32  load word, registered.
REQ-009 ready  output  1  access complete or idle; pipeline freeze = ~ready.
REQ-010 sram_addr  output  18  SRAM halfword address.
REQ-011 sram_dq_out  output  16  SRAM write data.
REQ-012 sram_dq_in  input  16  SRAM read data.
REQ-013 sram_dq_oe  output  1  drives sram_dq_out onto the bus when 1.
REQ-014 sram_we_n  output  1  SRAM write strobe, active low.

Function
REQ-015 FSM states: IDLE, LOW, HIGH, DONE.
REQ-016 IDLE: on (rd_en|wr_en) -> LOW; else stay in IDLE with ready=1.
REQ-017 ready SHALL be 0 when (rd_en|wr_en)=1 and state != DONE; ready SHALL be 1 in DONE and in IDLE with no request.
REQ-018 LOW and HIGH SHALL each last WAIT_CYCLES+1 cycles, counted by a 3-bit phase counter cleared on each state entry.
REQ-019 DONE SHALL last exactly one cycle, then -> IDLE unconditionally, even if the request is still high.
REQ-020 Latency: a request first sampled in IDLE at cycle 0 SHALL give ready=1 at cycle 2*WAIT_CYCLES+3 (cycle 5 for the default).
REQ-021 Address map: off = address-1024; word = off[18:2]; sram_addr = {word,0} in LOW and {word,1} in HIGH; address[1:0] ignored; out-of-range addresses wrap modulo 2^19.
REQ-022 Write: sram_dq_oe=1 and sram_we_n=0 throughout LOW/HIGH; sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-023 Read: sram_we_n=1 and sram_dq_oe=0; capture sram_dq_in into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
REQ-024 rd_en and wr_en both 1: treated as a write; read_data unchanged.
REQ-025 Outside LOW/HIGH: sram_we_n=1, sram_dq_oe=0; sram_addr holds its last value.

Reset
REQ-026 rst SHALL force state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
REQ-027 rst asserted mid-access SHALL abort the access on the next edge with no further SRAM strobe; the request, if still held, restarts from IDLE.

Configuration
REQ-028 Macro SRAM_WORD_CACHE_EN defined: a one-entry read cache holds a valid bit, a 17-bit word tag and a 32-bit data word.
REQ-029 With the macro, a read in IDLE that hits a valid entry SHALL give ready=1 in the same cycle, with read_data driven from the cache; it SHALL start no SRAM access and SHALL leave the state at IDLE.
REQ-030 With the macro, each completed read SHALL fill the entry; a write to the tagged word SHALL clear valid in DONE; rst SHALL clear valid.
REQ-031 Without the macro, no cache storage exists and every read takes the REQ-020 latency.

Structure
REQ-032 Package sram_ctrl_pkg SHALL hold the state enum, SRAM_BASE_ADDR=1024, SRAM_ADDR_W=18 and SRAM_DATA_W=16.
REQ-033 No sub-module is required: the FSM, counter, address map and cache are inline.

Verification
REQ-034 Reset, then write 0xDEADBEEF at address 1024 -> halfword 0 = 0xBEEF, halfword 1 = 0xDEAD, ready=1 at cycle 5 only.
REQ-035 Read address 1024 after REQ-034 -> read_data = 0xDEADBEEF in DONE, sram_we_n stays 1.
REQ-036 WAIT_CYCLES=3, read address 1028 -> ready at cycle 9; sram_addr = 2 then 3, each held 4 cycles.
REQ-037 rst pulsed during the HIGH phase of a write -> sram_we_n=1 on the next cycle and halfword 1 unwritten.
REQ-038 SRAM_WORD_CACHE_EN, two back-to-back reads of address 1032 -> second read has ready=1 in cycle 0 with no sram_addr change; a write to 1032 followed by a read -> full-latency access.
